// File: rtl/updown_counter_ext.sv
// Parametrised up/down counter with programmable modulus, load/clear, wrap or saturate mode.
// Define UPDOWN_COUNTER_EXT_TERMCNT_EN to add tc_cnt_o, a saturating count of wrap pulses.
module updown_counter_ext #(
    parameter int Width     = 8,
    parameter int StepWidth = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 clr_i,
    input  logic                 load_i,
    input  logic [Width-1:0]     load_val_i,
    input  logic [Width-1:0]     max_val_i,
    input  logic                 en_i,
    input  logic                 up_i,
    input  logic [StepWidth-1:0] step_i,
    input  logic                 sat_i,
    output logic [Width-1:0]     cnt_o,
    output logic                 max_tick_o,
    output logic                 min_tick_o,
    output logic                 wrap_o,
    output logic                 sat_o
`ifdef UPDOWN_COUNTER_EXT_TERMCNT_EN
    ,
    output logic [7:0]           tc_cnt_o
`endif
);

    // One bit wider than the larger operand so max_val_i + 1 and cnt + step never overflow.
    localparam int XW = ((Width > StepWidth) ? Width : StepWidth) + 1;

    logic [XW-1:0]    cnt_x, max_x, step_x, load_x, bound_x, res_x;
    logic [Width-1:0] cnt_d;
    logic             wrap_d, sat_d;

    always_comb begin
        cnt_x   = XW'(cnt_o);
        max_x   = XW'(max_val_i);
        step_x  = XW'(step_i);
        load_x  = XW'(load_val_i);
        bound_x = max_x + XW'(1);
        res_x   = cnt_x;
        wrap_d  = 1'b0;
        sat_d   = 1'b0;

        if (clr_i) begin
            res_x = '0;
        end else if (load_i) begin
            if (load_x > max_x) begin
                res_x = max_x;
                sat_d = 1'b1;
            end else begin
                res_x = load_x;
            end
        end else if (en_i && (step_i != '0)) begin
            if (up_i) begin
                // A count left above a lowered bound restarts from the bottom or pins to the top.
                if (cnt_x > max_x) begin
                    if (sat_i) begin
                        res_x = max_x;
                        sat_d = 1'b1;
                    end else begin
                        res_x  = '0;
                        wrap_d = 1'b1;
                    end
                end else if ((cnt_x + step_x) <= max_x) begin
                    res_x = cnt_x + step_x;
                end else if (sat_i) begin
                    res_x = max_x;
                    sat_d = 1'b1;
                end else begin
                    res_x  = (cnt_x + step_x) - bound_x;
                    wrap_d = 1'b1;
                end
            end else begin
                if (cnt_x >= step_x) begin
                    res_x = cnt_x - step_x;
                end else if (sat_i) begin
                    res_x = '0;
                    sat_d = 1'b1;
                end else begin
                    res_x  = bound_x - (step_x - cnt_x);
                    wrap_d = 1'b1;
                end
            end
        end
        cnt_d = res_x[Width-1:0];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_o  <= '0;
            wrap_o <= 1'b0;
            sat_o  <= 1'b0;
        end else begin
            cnt_o  <= cnt_d;
            wrap_o <= wrap_d;
            sat_o  <= sat_d;
        end
    end

    assign max_tick_o = (cnt_o == max_val_i);
    assign min_tick_o = (cnt_o == '0);

`ifdef UPDOWN_COUNTER_EXT_TERMCNT_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tc_cnt_o <= '0;
        end else if (clr_i) begin
            tc_cnt_o <= '0;
        end else if (wrap_d && (tc_cnt_o != 8'hff)) begin
            tc_cnt_o <= tc_cnt_o + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_updown_counter_ext.sv
// Scoreboard bench for updown_counter_ext: expected state is queued at drive time, checked after the edge.
module tb_updown_counter_ext;

    localparam int W  = 8;
    localparam int SW = 4;

    logic          clk_i = 1'b0;
    logic          rst_i, clr_i, load_i, en_i, up_i, sat_i;
    logic [W-1:0]  load_val_i, max_val_i;
    logic [SW-1:0] step_i;
    logic [W-1:0]  cnt_o;
    logic          max_tick_o, min_tick_o, wrap_o, sat_o;
`ifdef UPDOWN_COUNTER_EXT_TERMCNT_EN
    logic [7:0]    tc_cnt_o;
`endif

    updown_counter_ext #(.Width(W), .StepWidth(SW)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .clr_i(clr_i), .load_i(load_i),
        .load_val_i(load_val_i), .max_val_i(max_val_i), .en_i(en_i), .up_i(up_i),
        .step_i(step_i), .sat_i(sat_i), .cnt_o(cnt_o), .max_tick_o(max_tick_o),
        .min_tick_o(min_tick_o), .wrap_o(wrap_o), .sat_o(sat_o)
`ifdef UPDOWN_COUNTER_EXT_TERMCNT_EN
        , .tc_cnt_o(tc_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int cnt;
        bit wrap;
        bit sat;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   m_cnt = 0;
    int   mv    = 9;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic, wrap expressed as a modulo of (mv + 1).
    task automatic cycle(input bit c, input bit l, input int lv, input bit e,
                         input bit u, input int s, input bit st, input string tag);
        exp_t x;
        @(negedge clk_i);
        clr_i = c; load_i = l; load_val_i = W'(lv); en_i = e; up_i = u;
        step_i = SW'(s); sat_i = st; max_val_i = W'(mv);
        x.cnt = m_cnt; x.wrap = 1'b0; x.sat = 1'b0;
        if (c) x.cnt = 0;
        else if (l) begin
            x.cnt = (lv > mv) ? mv : lv;
            x.sat = (lv > mv);
        end else if (e && s != 0) begin
            if (u) begin
                if (m_cnt > mv) begin
                    if (st) begin x.cnt = mv; x.sat = 1'b1; end
                    else    begin x.cnt = 0;  x.wrap = 1'b1; end
                end else if (m_cnt + s <= mv) x.cnt = m_cnt + s;
                else if (st) begin x.cnt = mv; x.sat = 1'b1; end
                else begin x.cnt = (m_cnt + s) % (mv + 1); x.wrap = 1'b1; end
            end else begin
                if (m_cnt >= s) x.cnt = m_cnt - s;
                else if (st) begin x.cnt = 0; x.sat = 1'b1; end
                else begin x.cnt = (m_cnt - s + mv + 1) % (mv + 1); x.wrap = 1'b1; end
            end
        end
        m_cnt = x.cnt;
        sb.push_back(x);
        @(posedge clk_i);
        #1;
        chk({tag, " sb_level"}, sb.size(), 1);
        if (sb.size() > 0) begin
            x = sb.pop_front();
            chk({tag, " cnt"}, cnt_o, x.cnt);
            chk({tag, " wrap"}, wrap_o, x.wrap);
            chk({tag, " sat"}, sat_o, x.sat);
            chk({tag, " max_tick"}, max_tick_o, (x.cnt == mv));
            chk({tag, " min_tick"}, min_tick_o, (x.cnt == 0));
        end
    endtask

    initial begin
        rst_i = 1'b1; clr_i = 1'b0; load_i = 1'b0; en_i = 1'b0; up_i = 1'b0;
        sat_i = 1'b0; load_val_i = '0; step_i = '0; max_val_i = 8'd9;
        #1;
        chk("reset cnt", cnt_o, 0);
        chk("reset min_tick", min_tick_o, 1);
        chk("reset max_tick", max_tick_o, 0);
        chk("reset wrap", wrap_o, 0);
        chk("reset sat", sat_o, 0);
        @(negedge clk_i);
        rst_i = 1'b0;
        m_cnt = 0;

        for (int i = 0; i < 12; i++) cycle(0, 0, 0, 1, 1, 1, 0, "up1_wrap");
        cycle(1, 0, 0, 0, 0, 0, 0, "clr");
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1, 1, 4, 1, "up4_sat");
        cycle(0, 1, 1, 0, 0, 0, 0, "load1");
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1, 0, 3, 0, "dn3_wrap");
        cycle(0, 1, 15, 0, 0, 0, 0, "load_clamp");
        cycle(1, 1, 15, 0, 0, 0, 0, "clr_over_load");
        cycle(0, 0, 0, 1, 0, 2, 1, "dn_sat_floor");
        cycle(0, 1, 5, 0, 0, 0, 0, "load5");
        cycle(0, 0, 0, 1, 1, 10, 0, "up_full_step");
        cycle(0, 0, 0, 1, 0, 10, 0, "dn_full_step");
        cycle(0, 0, 0, 1, 1, 0, 0, "step0_hold");
        cycle(0, 0, 0, 0, 1, 3, 0, "en0_hold");

        // Lower the bound under a count that now lies above it.
        cycle(0, 1, 9, 0, 0, 0, 0, "load9");
        mv = 5;
        cycle(0, 0, 0, 1, 1, 1, 0, "shrink_wrap");
        cycle(0, 1, 5, 0, 0, 0, 0, "load5b");
        mv = 9;
        cycle(0, 1, 8, 0, 0, 0, 0, "load8");
        mv = 3;
        cycle(0, 0, 0, 1, 1, 2, 1, "shrink_sat");
        mv = 9;
        cycle(0, 1, 8, 0, 0, 0, 0, "load8b");
        mv = 4;
        cycle(0, 0, 0, 1, 0, 1, 0, "shrink_down");

        for (int i = 0; i < 300; i++) begin
            int s_max;
            if ($urandom_range(0, 15) == 0) mv = $urandom_range(0, 20);
            s_max = (mv + 1 < 15) ? mv + 1 : 15;
            cycle($urandom_range(0, 19) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 31),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom_range(0, s_max),
                  $urandom_range(0, 1), "rand");
        end

        mv = 9;
        cycle(0, 1, 7, 0, 0, 0, 0, "load7");
        @(posedge clk_i);
        #3;
        rst_i = 1'b1;
        #1;
        chk("async_rst cnt", cnt_o, 0);
        chk("async_rst min_tick", min_tick_o, 1);
        @(negedge clk_i);
        rst_i = 1'b0;
        m_cnt = 0;

`ifdef UPDOWN_COUNTER_EXT_TERMCNT_EN
        cycle(0, 1, 9, 0, 0, 0, 0, "tc_load");
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1, 1, 10, 0, "tc_wrap");
        chk("tc_cnt after 3 wraps", tc_cnt_o, 3);
        @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        chk("tc_cnt after reset", tc_cnt_o, 0);
        @(negedge clk_i);
        rst_i = 1'b0;
        m_cnt = 0;
`endif

        chk("sb drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
